// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the HC4051 scan sequencer.
package mux_scan_pkg;
    localparam int SEL_W = 3;
    localparam int NCH   = 8;
    localparam int TMR_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_WAIT    = 3'd4,
        ST_STORE   = 3'd5,
        ST_FINISH  = 3'd6
    } scan_state_e;
endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; tc is high whenever the count sits at zero.
module scan_timer #(
    parameter int W = 10
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)        cnt <= '0;
        else if (load)      cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/mux_scan_ctl.sv
// Steps the 8:1 mux through a channel mask with break-before-make, settle
// delay and one ADC conversion per channel; results are tagged by channel.
module mux_scan_ctl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int ADC_TIMEOUT   = 64,
    parameter int ADC_WIDTH     = 12
) (
    input  logic                 CLK,
    input  logic                 RESET_,
    input  logic                 START,
    input  logic [NCH-1:0]       CHAN_MASK,
    input  logic                 ADC_DONE,
    input  logic [ADC_WIDTH-1:0] ADC_DATA,
    output logic [SEL_W-1:0]     S,
    output logic                 ENABLE_,
    output logic                 ADC_CONVST,
    output logic [ADC_WIDTH-1:0] RESULT_DATA,
    output logic [SEL_W-1:0]     RESULT_CHAN,
    output logic                 RESULT_ERR,
    output logic                 RESULT_VALID,
    output logic                 SCAN_BUSY,
    output logic                 SCAN_DONE
);
    // Timer is loaded with N-1 so that tc lands on the Nth cycle of the state.
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LD    = TMR_W'(ADC_TIMEOUT - 1);

    scan_state_e        state, nxt;
    logic [NCH-1:0]     mask_q;
    logic               found;
    logic [SEL_W-1:0]   idx;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_tc;

    scan_timer #(.W(TMR_W)) u_tmr (
        .gclk     (CLK),
        .grst_n   (RESET_),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Lowest remaining channel; descending loop so the lowest index wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                found = 1'b1;
                idx   = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) state <= ST_IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt      = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            ST_IDLE:    if (START) nxt = ST_SELECT;
            ST_SELECT: begin
                if (found) begin
                    nxt      = ST_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end else begin
                    nxt = ST_FINISH;
                end
            end
            ST_SETTLE:  if (tmr_tc) nxt = ST_CONVERT;
            ST_CONVERT: begin
                nxt      = ST_WAIT;
                tmr_load = 1'b1;
                tmr_val  = TMO_LD;
            end
            ST_WAIT:    if (ADC_DONE || tmr_tc) nxt = ST_STORE;
            ST_STORE:   nxt = ST_SELECT;
            ST_FINISH:  nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
    end

    // Mux stays enabled from settle through the end of the conversion.
    assign ENABLE_      = !(state inside {ST_SETTLE, ST_CONVERT, ST_WAIT});
    assign ADC_CONVST   = (state == ST_CONVERT);
    assign RESULT_VALID = (state == ST_STORE);
    assign SCAN_DONE    = (state == ST_FINISH);
    assign SCAN_BUSY    = (state != ST_IDLE) && (state != ST_FINISH);

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            mask_q      <= '0;
            S           <= '0;
            RESULT_DATA <= '0;
            RESULT_CHAN <= '0;
            RESULT_ERR  <= 1'b0;
        end else begin
            if (state == ST_IDLE && START)
                mask_q <= CHAN_MASK;
            if (state == ST_SELECT && found) begin
                S           <= idx;
                mask_q[idx] <= 1'b0;
            end
            // ADC_DONE takes priority over a timeout expiring in the same cycle.
            if (state == ST_WAIT) begin
                if (ADC_DONE) begin
                    RESULT_DATA <= ADC_DATA;
                    RESULT_ERR  <= 1'b0;
                    RESULT_CHAN <= S;
                end else if (tmr_tc) begin
                    RESULT_DATA <= '0;
                    RESULT_ERR  <= 1'b1;
                    RESULT_CHAN <= S;
                end
            end
        end
    end
endmodule

// File: tb/tb_mux_scan_ctl.sv
// Bench for mux_scan_ctl: table vectors, hand sequences and random scans
// against a cycle-arithmetic model of the scan timeline.
module tb_mux_scan_ctl;
    localparam int SET = 4;
    localparam int TO  = 64;
    localparam int AW  = 12;

    logic          CLK = 1'b0;
    logic          RESET_, START, ADC_DONE;
    logic [7:0]    CHAN_MASK;
    logic [AW-1:0] ADC_DATA;
    logic [2:0]    S, RESULT_CHAN;
    logic          ENABLE_, ADC_CONVST, RESULT_ERR, RESULT_VALID, SCAN_BUSY, SCAN_DONE;
    logic [AW-1:0] RESULT_DATA;

    always #5 CLK = ~CLK;

    mux_scan_ctl #(.SETTLE_CYCLES(SET), .ADC_TIMEOUT(TO), .ADC_WIDTH(AW)) dut (
        .CLK(CLK), .RESET_(RESET_), .START(START), .CHAN_MASK(CHAN_MASK),
        .ADC_DONE(ADC_DONE), .ADC_DATA(ADC_DATA), .S(S), .ENABLE_(ENABLE_),
        .ADC_CONVST(ADC_CONVST), .RESULT_DATA(RESULT_DATA), .RESULT_CHAN(RESULT_CHAN),
        .RESULT_ERR(RESULT_ERR), .RESULT_VALID(RESULT_VALID), .SCAN_BUSY(SCAN_BUSY),
        .SCAN_DONE(SCAN_DONE)
    );

    int nchecks = 0;
    int nerrors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ADC behaviour per channel: delay after CONVST (0 = never answers).
    int            resp_dly [8];
    logic [AW-1:0] resp_dat [8];

    initial begin
        ADC_DONE = 1'b0;
        ADC_DATA = '0;
        forever begin
            @(negedge CLK);
            ADC_DONE = 1'b0;
            ADC_DATA = AW'($urandom);
            if (ADC_CONVST === 1'b1) begin
                int d;
                logic [AW-1:0] v;
                d = resp_dly[S];
                v = resp_dat[S];
                if (d > 0) begin
                    repeat (d) begin
                        @(negedge CLK);
                        ADC_DATA = AW'($urandom);
                    end
                    ADC_DONE = 1'b1;
                    ADC_DATA = v;
                end
            end
        end
    end

    // Observation monitor, cycles counted relative to the accepting edge.
    bit   mon_on = 0;
    bit   mon_was = 0;
    int   base = 0;
    int   obs_t[$], obs_ch[$], obs_dat[$], obs_err[$], done_q[$];
    int   n_conv, n_enlo, n_busy, viol, hi_run;
    bit   prev_en, seen_lo;
    logic [2:0] prev_s;

    always @(negedge CLK) begin
        if (mon_on) begin
            if (!mon_was) begin
                obs_t.delete(); obs_ch.delete(); obs_dat.delete(); obs_err.delete(); done_q.delete();
                n_conv = 0; n_enlo = 0; n_busy = 0; viol = 0; hi_run = 0;
                seen_lo = 0; prev_en = ENABLE_; prev_s = S;
            end
            if (RESULT_VALID) begin
                obs_t.push_back(cyc - base); obs_ch.push_back(int'(RESULT_CHAN));
                obs_dat.push_back(int'(RESULT_DATA)); obs_err.push_back(int'(RESULT_ERR));
                if (!ENABLE_) viol++;
            end
            if (SCAN_DONE)  done_q.push_back(cyc - base);
            if (ADC_CONVST) n_conv++;
            if (SCAN_BUSY)  n_busy++;
            if (S !== prev_s && !prev_en) viol++;
            if (ENABLE_) hi_run++;
            else begin
                n_enlo++;
                if (prev_en && seen_lo && hi_run < 2) viol++;
                seen_lo = 1;
                hi_run = 0;
            end
            prev_en = ENABLE_;
            prev_s  = S;
        end
        mon_was = mon_on;
    end

    task automatic run_scan(input logic [7:0] mask, input bit noise,
                            output int nres, output int nerr_o, output int done_o);
        int e_t[$], e_ch[$], e_dat[$], e_err[$];
        int t, enlo, nch, exp_done, n;
        bit got;
        t = 1; enlo = 0; nch = 0;
        for (int ch = 0; ch < 8; ch++) begin
            if (mask[ch]) begin
                int d, dd, conv, store;
                bit ok;
                d  = resp_dly[ch];
                ok = (d >= 1 && d <= TO);
                dd = ok ? d : TO;
                conv  = t + SET + 1;
                store = conv + dd + 1;
                e_t.push_back(store); e_ch.push_back(ch);
                e_dat.push_back(ok ? int'(resp_dat[ch]) : 0); e_err.push_back(ok ? 0 : 1);
                enlo += SET + 1 + dd;
                nch++;
                t = store + 1;
            end
        end
        exp_done = t + 1;

        @(negedge CLK);
        START = 1'b1; CHAN_MASK = mask;
        base = cyc; mon_on = 1;
        @(negedge CLK);
        START = 1'b0;
        got = 0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge CLK);
            if (SCAN_DONE) begin
                got = 1; START = 1'b0;
            end else if (noise) begin
                START = 1'($urandom); CHAN_MASK = 8'($urandom);
            end
        end
        @(negedge CLK);
        mon_on = 0; START = 1'b0;
        if (!got) chk("scan_done_timeout", 0, 1);

        chk("done_count", done_q.size(), 1);
        done_o = (done_q.size() > 0) ? done_q[0] : -1;
        chk("done_cycle", done_o, exp_done);
        chk("n_results", obs_t.size(), e_t.size());
        n = (obs_t.size() < e_t.size()) ? obs_t.size() : e_t.size();
        nerr_o = 0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("res_cycle[%0d]", i), obs_t[i], e_t[i]);
            chk($sformatf("res_chan[%0d]", i), obs_ch[i], e_ch[i]);
            chk($sformatf("res_data[%0d]", i), obs_dat[i], e_dat[i]);
            chk($sformatf("res_err[%0d]", i), obs_err[i], e_err[i]);
        end
        foreach (obs_err[i]) nerr_o += obs_err[i];
        nres = obs_t.size();
        chk("n_convst", n_conv, nch);
        chk("enable_low_cycles", n_enlo, enlo);
        chk("busy_cycles", n_busy, exp_done - 1);
        chk("mux_order_viol", viol, 0);
        if (e_ch.size() > 0) chk("result_chan_hold", RESULT_CHAN, e_ch[e_ch.size()-1]);
    endtask

    typedef struct {
        logic [7:0]        mask;
        int                dly;
        logic [7:0][AW-1:0] dat;
        bit                noise;
        int                exp_nres;
        int                exp_nerr;
        int                exp_done;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int nres, nerr_o, done_o, cnt;
        bit hit;
        RESET_ = 1'b0; START = 1'b0; CHAN_MASK = '0;
        for (int i = 0; i < 8; i++) begin resp_dly[i] = 1; resp_dat[i] = '0; end

        repeat (2) @(negedge CLK);
        chk("rst_S", S, 0);             chk("rst_ENABLE_", ENABLE_, 1);
        chk("rst_CONVST", ADC_CONVST, 0); chk("rst_RDATA", RESULT_DATA, 0);
        chk("rst_RCHAN", RESULT_CHAN, 0); chk("rst_RERR", RESULT_ERR, 0);
        chk("rst_RVALID", RESULT_VALID, 0); chk("rst_BUSY", SCAN_BUSY, 0);
        chk("rst_DONE", SCAN_DONE, 0);
        RESET_ = 1'b1;
        repeat (2) @(negedge CLK);

        // mask, delay, data, noise, results, timeouts, done cycle
        foreach (vecs[i]) vecs[i].dat = '0;
        vecs[0] = '{8'b1010_0001, 3,  vecs[0].dat, 0, 3, 0, 32};
        vecs[0].dat[0] = 12'h123; vecs[0].dat[5] = 12'h456; vecs[0].dat[7] = 12'h789;
        vecs[1] = '{8'h00, 1,  vecs[1].dat, 0, 0, 0, 2};
        vecs[2] = '{8'h08, 0,  vecs[2].dat, 0, 1, 1, 73};
        vecs[3] = '{8'h80, TO, vecs[3].dat, 0, 1, 0, 73};
        vecs[3].dat[7] = 12'hA5C;
        vecs[4] = '{8'h10, TO + 1, vecs[4].dat, 0, 1, 1, 73};
        vecs[4].dat[4] = 12'hFFF;
        vecs[5] = '{8'h03, 1,  vecs[5].dat, 1, 2, 0, 18};
        vecs[5].dat[0] = 12'h0F0; vecs[5].dat[1] = 12'h00F;
        vecs[6] = '{8'hFF, 2,  vecs[6].dat, 0, 8, 0, 74};
        for (int c = 0; c < 8; c++) vecs[6].dat[c] = AW'(12'h100 * c + c);

        for (int i = 0; i < 7; i++) begin
            for (int c = 0; c < 8; c++) begin
                resp_dly[c] = vecs[i].dly; resp_dat[c] = vecs[i].dat[c];
            end
            run_scan(vecs[i].mask, vecs[i].noise, nres, nerr_o, done_o);
            chk($sformatf("vec%0d_nres", i), nres, vecs[i].exp_nres);
            chk($sformatf("vec%0d_nerr", i), nerr_o, vecs[i].exp_nerr);
            chk($sformatf("vec%0d_done", i), done_o, vecs[i].exp_done);
        end

        // Back-to-back: START in the SCAN_DONE cycle ignored, next cycle accepted.
        @(negedge CLK); START = 1'b1; CHAN_MASK = 8'h00;
        @(negedge CLK); START = 1'b0;
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge CLK);
            if (SCAN_DONE) begin hit = 1; START = 1'b1; end
        end
        chk("b2b_first_done", hit, 1);
        @(negedge CLK); chk("b2b_ignored_busy", SCAN_BUSY, 0);
        @(negedge CLK); chk("b2b_accepted_busy", SCAN_BUSY, 1); START = 1'b0;
        @(negedge CLK); chk("b2b_second_done", SCAN_DONE, 1);
        repeat (2) @(negedge CLK);

        // Reset during second channel's settle of a full scan.
        for (int c = 0; c < 8; c++) begin resp_dly[c] = 1; resp_dat[c] = 12'hABC; end
        @(negedge CLK); START = 1'b1; CHAN_MASK = 8'hFF;
        @(negedge CLK); START = 1'b0;
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge CLK);
            if (!ENABLE_ && S == 3'd1 && !ADC_CONVST) hit = 1;
        end
        chk("rst_mid_reached_settle", hit, 1);
        RESET_ = 1'b0;
        #1;
        chk("rst_mid_ENABLE_", ENABLE_, 1); chk("rst_mid_S", S, 0);
        chk("rst_mid_BUSY", SCAN_BUSY, 0);  chk("rst_mid_RDATA", RESULT_DATA, 0);
        chk("rst_mid_CONVST", ADC_CONVST, 0);
        repeat (2) @(negedge CLK);
        RESET_ = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge CLK);
            if (SCAN_DONE || SCAN_BUSY || !ENABLE_) cnt++;
        end
        chk("rst_mid_abandoned", cnt, 0);

        // Random scans with late, exact-timeout and missing ADC answers.
        for (int r = 0; r < 6; r++) begin
            logic [7:0] m;
            m = 8'($urandom);
            for (int c = 0; c < 8; c++) begin
                int sel;
                sel = $urandom_range(0, 9);
                if (sel == 0)      resp_dly[c] = 0;
                else if (sel == 1) resp_dly[c] = TO + $urandom_range(0, 3);
                else               resp_dly[c] = $urandom_range(1, 12);
                resp_dat[c] = AW'($urandom);
            end
            run_scan(m, 1'($urandom_range(0, 1)), nres, nerr_o, done_o);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule

// File: doc/mux_scan_ctl.md
# mux_scan_ctl

Sequencer directly upstream of the HC4051 8:1 analog mux. Steps the mux select lines through a programmable set of channels, opening the mux with break-before-make, waiting a settling interval, firing one ADC conversion per channel, and reporting each result tagged with its channel number. Sits between the board control logic (start/mask) and the mux/ADC pair.

## Interface
- SETTLE_CYCLES, 16: cycles ENABLE_ is held low before conversion start; legal range 1..255.
- ADC_TIMEOUT, 64: maximum cycles to wait for ADC_DONE after ADC_CONVST; legal range 2..1023.
- ADC_WIDTH, 12: width of ADC result.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET_  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle scan request; ignored while SCAN_BUSY.
- CHAN_MASK  in  8  bit n set = scan channel n; sampled only on accepted START.
- ADC_DONE  in  1  one-cycle pulse, conversion complete.
- ADC_DATA  in  ADC_WIDTH  conversion result, valid in ADC_DONE cycle.
- S  out  3  mux address.
- ENABLE_  out  1  mux enable, active low.
- ADC_CONVST  out  1  one-cycle conversion start pulse.
- RESULT_DATA  out  ADC_WIDTH  captured sample.
- RESULT_CHAN  out  3  channel of RESULT_DATA.
- RESULT_ERR  out  1  sample timed out; RESULT_DATA forced to 0.
- RESULT_VALID  out  1  one-cycle pulse, RESULT_* valid.
- SCAN_BUSY  out  1  high from accepted START until SCAN_DONE.
- SCAN_DONE  out  1  one-cycle pulse, scan finished.

## Operation
- Reset values: S=0, ENABLE_=1, ADC_CONVST=0, RESULT_DATA=0, RESULT_CHAN=0, RESULT_ERR=0, RESULT_VALID=0, SCAN_BUSY=0, SCAN_DONE=0; state IDLE; internal mask cleared.
- States: IDLE, SELECT, SETTLE, CONVERT, WAIT, STORE, FINISH.
- IDLE: START=1 -> latch CHAN_MASK, SCAN_BUSY=1, go SELECT.
- SELECT: find lowest set bit of remaining mask; none -> FINISH; else S<=index, clear that bit, ENABLE_ stays 1, go SETTLE.
- SETTLE: ENABLE_=0; counter runs SETTLE_CYCLES cycles, then CONVERT.
- CONVERT: ADC_CONVST=1 for exactly one cycle, timeout counter cleared, go WAIT.
- WAIT: ADC_DONE=1 -> capture ADC_DATA, RESULT_ERR=0, go STORE; counter reaches ADC_TIMEOUT -> RESULT_DATA=0, RESULT_ERR=1, go STORE. If both occur in the same cycle, ADC_DONE wins.
- STORE: RESULT_VALID=1, RESULT_CHAN=S; ENABLE_=1 (break before next select); go SELECT.
- FINISH: SCAN_DONE=1, SCAN_BUSY=0, ENABLE_=1, go IDLE.
- ADC_DONE outside WAIT is ignored. CHAN_MASK changes during scan have no effect.
- Mask 0: no ENABLE_ low, no ADC_CONVST; SCAN_DONE follows SELECT.
- RESULT_DATA/CHAN/ERR hold until next STORE.
- RESET_ low mid-scan: all outputs to reset values immediately; scan abandoned, no SCAN_DONE.

## Timing
- START accepted at edge 0 -> SELECT at cycle 1 (S updates at end of cycle 1), ENABLE_ low cycles 2..1+SETTLE_CYCLES, ADC_CONVST in cycle 2+SETTLE_CYCLES.
- ADC_DONE in WAIT cycle k -> RESULT_VALID next cycle.
- S never changes while ENABLE_=0; ENABLE_ is high at least one full cycle (STORE plus SELECT) between channels.
- Per-channel time with ADC_DONE d cycles after CONVST: SETTLE_CYCLES+d+3 cycles.
- Back-to-back: START in the SCAN_DONE cycle is ignored; START in the following cycle is accepted.

## Structure
- Package mux_scan_pkg: state encoding constants, SEL_W=3, NCH=8.
- Sub-module scan_timer: loadable down-counter with terminal-count flag, shared for settle and timeout (width 10).
- Priority encoder for lowest set mask bit kept inline.

## Test plan
- Reset mid-SETTLE with mask 8'hFF -> ENABLE_=1, S=0, SCAN_BUSY=0 same cycle; no SCAN_DONE.
- SETTLE_CYCLES=4, mask 8'b1010_0001, ADC_DONE 3 cycles after each CONVST with data 12'h123/456/789 -> RESULT_CHAN 0,5,7 with matching data, SCAN_DONE after third RESULT_VALID, ENABLE_ high at each S change.
- Mask 8'h00 -> SCAN_DONE 2 cycles after START, ENABLE_ never low, no ADC_CONVST.
- No ADC_DONE on channel 3 (mask 8'h08), ADC_TIMEOUT=64 -> RESULT_VALID with RESULT_ERR=1, RESULT_DATA=0, RESULT_CHAN=3.
- ADC_DONE in the same cycle as timeout expiry -> RESULT_ERR=0, data captured.
- START pulses and CHAN_MASK changes during a scan of mask 8'h03 -> ignored; exactly two results, channels 0 and 1.
